// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: each stage resolves one WIDTH/STAGES-bit
// CLA slice, registers the slice carry, and carries pending operand slices alongside.
module cla_pipe_addsub #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf,
   output logic             zero
);

   localparam int unsigned W_S  = WIDTH / STAGES;
   localparam int unsigned NG   = (W_S + 3) / 4;
   localparam int unsigned LAST = STAGES - 1;

   // Pipe register k holds the operation after slice k has been resolved;
   // register LAST is the output register.
   logic [WIDTH-1:0] a_p [STAGES];
   logic [WIDTH-1:0] b_p [STAGES];
   logic [WIDTH-1:0] s_p [STAGES];
   logic             c_p [STAGES];
   logic             v_p [STAGES];
   logic             ovf_r;
   logic             zero_r;

   logic [WIDTH-1:0] src_a [STAGES];
   logic [WIDTH-1:0] src_b [STAGES];
   logic [WIDTH-1:0] src_s [STAGES];
   logic             src_c [STAGES];
   logic             src_v [STAGES];
   logic [WIDTH-1:0] nxt_s [STAGES];
   logic             nxt_c [STAGES];
   logic             ovf_n;
   logic             zero_n;

   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
   logic             adv;

   // Returns carries c[0..W_S] of one slice. Group carries and in-group bit carries
   // are both written as flat sum-of-products so nothing ripples between groups.
   function automatic logic [W_S:0] cla_carries(
      input logic [W_S-1:0] x,
      input logic [W_S-1:0] y,
      input logic           ci
   );
      logic [W_S-1:0] g;
      logic [W_S-1:0] p;
      logic [NG-1:0]  gg;
      logic [NG-1:0]  gp;
      logic [NG:0]    gc;
      logic [W_S:0]   c;
      logic           t;
      int unsigned    base;
      g  = x & y;
      p  = x ^ y;
      gg = '0;
      gp = '1;
      c  = '0;
      for (int unsigned j = 0; j < NG; j++) begin
         for (int unsigned i = 4 * j; i < 4 * j + 4 && i < W_S; i++) begin
            gg[j] = g[i] | (p[i] & gg[j]);
            gp[j] = gp[j] & p[i];
         end
      end
      gc[0] = ci;
      for (int unsigned j = 1; j <= NG; j++) begin
         t = ci;
         for (int unsigned m = 0; m < j; m++) t = t & gp[m];
         gc[j] = t;
         for (int unsigned i = 0; i < j; i++) begin
            t = gg[i];
            for (int unsigned m = i + 1; m < j; m++) t = t & gp[m];
            gc[j] = gc[j] | t;
         end
      end
      for (int unsigned i = 0; i < W_S; i++) begin
         base = (i / 4) * 4;
         t = gc[i / 4];
         for (int unsigned m = base; m < i; m++) t = t & p[m];
         c[i] = t;
         for (int unsigned k = base; k < i; k++) begin
            t = g[k];
            for (int unsigned m = k + 1; m < i; m++) t = t & p[m];
            c[i] = c[i] | t;
         end
      end
      c[W_S] = gc[NG];
      return c;
   endfunction

   assign b_eff   = sub ? ~b : b;
   assign cin_eff = sub | c_in;
   assign adv     = ~v_p[LAST] | out_ready;
   assign in_ready = adv;

   always_comb begin
      src_a[0] = a;
      src_b[0] = b_eff;
      src_s[0] = '0;
      src_c[0] = cin_eff;
      src_v[0] = in_valid;
      for (int unsigned k = 1; k < STAGES; k++) begin
         src_a[k] = a_p[k-1];
         src_b[k] = b_p[k-1];
         src_s[k] = s_p[k-1];
         src_c[k] = c_p[k-1];
         src_v[k] = v_p[k-1];
      end
   end

   always_comb begin
      ovf_n  = 1'b0;
      zero_n = 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         logic [W_S:0] carries;
         carries  = cla_carries(src_a[k][k*W_S +: W_S], src_b[k][k*W_S +: W_S], src_c[k]);
         nxt_s[k] = src_s[k];
         nxt_s[k][k*W_S +: W_S] = src_a[k][k*W_S +: W_S] ^ src_b[k][k*W_S +: W_S]
                                  ^ carries[W_S-1:0];
         nxt_c[k] = carries[W_S];
         if (k == LAST) begin
            ovf_n  = carries[W_S] ^ carries[W_S-1];
            zero_n = ~|nxt_s[k];
         end
      end
   end

   // Data registers load only for valid operations so bubbles leave s/flags untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            a_p[k] <= '0;
            b_p[k] <= '0;
            s_p[k] <= '0;
            c_p[k] <= 1'b0;
            v_p[k] <= 1'b0;
         end
         ovf_r  <= 1'b0;
         zero_r <= 1'b0;
      end else if (adv) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            v_p[k] <= src_v[k];
            if (src_v[k]) begin
               a_p[k] <= src_a[k];
               b_p[k] <= src_b[k];
               s_p[k] <= nxt_s[k];
               c_p[k] <= nxt_c[k];
            end
         end
         if (src_v[LAST]) begin
            ovf_r  <= ovf_n;
            zero_r <= zero_n;
         end
      end
   end

   assign out_valid = v_p[LAST];
   assign s         = s_p[LAST];
   assign co        = c_p[LAST];
   assign ovf       = ovf_r;
   assign zero      = zero_r;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: directed vectors on the 32/4 build plus randomised
// streams with stalls on 8/1, 16/2 and 64/8 builds against an arithmetic model.
module tb_cla_pipe_addsub;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned STAGES = 4;
   localparam int unsigned NOPS   = 10000;
   localparam int unsigned LIMIT  = 60000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors      = 0;
   int checks      = 0;
   int sweeps_done = 0;

   logic             rst, in_valid, in_ready, c_in, sub, out_valid, out_ready, co, ovf, zero;
   logic [WIDTH-1:0] a, b, s;

   cla_pipe_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c_in(c_in), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .co(co), .ovf(ovf), .zero(zero)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        c_in;
      logic        sub;
      logic [31:0] s;
      logic        co;
      logic        ovf;
      logic        zero;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pick(input int unsigned w);
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      case ($urandom_range(0, 7))
         0: r = '1;
         1: r = '0;
         2: r = 64'd1 << (w - 1);
         3: r = (64'd1 << (w - 1)) - 64'd1;
         default: ;
      endcase
      return r;
   endfunction

   task automatic run_vec(input vec_t v, input int unsigned idx);
      int unsigned lat;
      @(negedge clk);
      a = v.a; b = v.b; c_in = v.c_in; sub = v.sub;
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk($sformatf("vec%0d_latency", idx), lat, STAGES - 1);
      chk($sformatf("vec%0d_result", idx), {out_valid, co, ovf, zero, s},
          {1'b1, v.co, v.ovf, v.zero, v.s});
   endtask

   initial begin
      vecs[0]  = '{32'd65535,    32'd11111,    1'b0, 1'b0, 32'd76646,    1'b0, 1'b0, 1'b0};
      vecs[1]  = '{32'd1021201,  32'd1457454,  1'b0, 1'b0, 32'd2478655,  1'b0, 1'b0, 1'b0};
      vecs[2]  = '{32'd6553500,  32'd1111145,  1'b0, 1'b1, 32'd5442355,  1'b1, 1'b0, 1'b0};
      vecs[3]  = '{32'd65455345, 32'd11145411, 1'b0, 1'b0, 32'd76600756, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[5]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{32'd5,        32'd7,        1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[8]  = '{32'd7,        32'd7,        1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[9]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 32'hACF13569, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h01000000, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset_outputs", {out_valid, co, ovf, zero, s}, '0);
      chk("reset_in_ready", in_ready, 1'b1);
      rst = 1'b0;

      for (int unsigned i = 0; i < 14; i++) run_vec(vecs[i], i);

      // back-to-back stream at full rate
      @(negedge clk);
      a = 32'd1021201; b = 32'd1457454; c_in = 1'b0; sub = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      a = 32'd6553500; b = 32'd1111145; sub = 1'b1;
      @(negedge clk);
      a = 32'd65455345; b = 32'd11145411; sub = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      chk("stream_gap", out_valid, 1'b0);
      @(negedge clk);
      chk("stream_r0", {out_valid, co, s}, {1'b1, 1'b0, 32'd2478655});
      @(negedge clk);
      chk("stream_r1", {out_valid, co, s}, {1'b1, 1'b1, 32'd5442355});
      @(negedge clk);
      chk("stream_r2", {out_valid, co, s}, {1'b1, 1'b0, 32'd76600756});
      @(negedge clk);
      chk("stream_end", out_valid, 1'b0);

      // backpressure: only STAGES operations fit while the output is blocked
      for (int unsigned i = 0; i < 10; i++) begin
         @(negedge clk);
         a = 32'd100 + i; b = i; c_in = 1'b0; sub = 1'b0;
         in_valid = 1'b1; out_ready = 1'b0;
         #1;
         chk($sformatf("bp_in_ready%0d", i), in_ready, i < STAGES);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      chk("bp_hold", {out_valid, s}, {1'b1, 32'd100});
      for (int unsigned i = 1; i < STAGES; i++) begin
         @(negedge clk);
         chk($sformatf("bp_drain%0d", i), {out_valid, s}, {1'b1, 32'd100 + 2 * i});
      end
      @(negedge clk);
      chk("bp_empty", out_valid, 1'b0);

      // reset with three operations in flight
      @(negedge clk);
      a = 32'd1; b = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      a = 32'd2;
      @(negedge clk);
      a = 32'd3;
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk("rst_flush", {out_valid, s}, '0);
      chk("rst_in_ready", in_ready, 1'b1);
      rst = 1'b0;
      for (int unsigned i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("rst_no_stale%0d", i), out_valid, 1'b0);
      end

      for (int unsigned i = 0; i < LIMIT && sweeps_done < 3; i++) @(negedge clk);
      chk("sweeps_finished", sweeps_done, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   for (genvar gi = 0; gi < 3; gi++) begin : sweep
      localparam int unsigned SW = (gi == 0) ? 8 : (gi == 1) ? 16 : 64;
      localparam int unsigned SS = (gi == 0) ? 1 : (gi == 1) ? 2 : 8;

      logic          sw_rst, sw_in_valid, sw_in_ready, sw_c_in, sw_sub;
      logic          sw_out_valid, sw_out_ready, sw_co, sw_ovf, sw_zero;
      logic [SW-1:0] sw_a, sw_b, sw_s;

      cla_pipe_addsub #(.WIDTH(SW), .STAGES(SS)) dut (
         .clk(clk), .rst(sw_rst), .in_valid(sw_in_valid), .in_ready(sw_in_ready),
         .a(sw_a), .b(sw_b), .c_in(sw_c_in), .sub(sw_sub),
         .out_valid(sw_out_valid), .out_ready(sw_out_ready),
         .s(sw_s), .co(sw_co), .ovf(sw_ovf), .zero(sw_zero)
      );

      initial begin : run
         logic [SW+2:0] q [$];
         logic [SW+2:0] exp_r;
         logic [SW:0]   full;
         logic [SW-1:0] be;
         logic [63:0]   r;
         int unsigned   sent;
         int unsigned   cyc;
         sent = 0;
         cyc  = 0;
         sw_rst = 1'b1; sw_in_valid = 1'b0; sw_out_ready = 1'b0;
         sw_a = '0; sw_b = '0; sw_c_in = 1'b0; sw_sub = 1'b0;
         repeat (2) @(negedge clk);
         sw_rst = 1'b0;
         while ((sent < NOPS || q.size() != 0) && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            sw_out_ready = (sent >= NOPS) || ($urandom_range(0, 3) != 0);
            if (sw_out_valid && sw_out_ready) begin
               chk($sformatf("sweep%0d_expected_pending", SW), q.size() != 0, 1'b1);
               if (q.size() != 0) begin
                  exp_r = q.pop_front();
                  chk($sformatf("sweep%0d_result", SW), {sw_co, sw_ovf, sw_zero, sw_s}, exp_r);
               end
            end
            sw_in_valid = (sent < NOPS) && ($urandom_range(0, 4) != 0);
            r = pick(SW);
            sw_a = r[SW-1:0];
            r = pick(SW);
            sw_b = r[SW-1:0];
            sw_c_in = 1'($urandom_range(0, 1));
            sw_sub  = 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("sweep%0d_in_ready", SW), sw_in_ready, !sw_out_valid || sw_out_ready);
            if (sw_in_valid && sw_in_ready) begin
               be   = sw_sub ? ~sw_b : sw_b;
               full = {1'b0, sw_a} + {1'b0, be} + {{SW{1'b0}}, sw_sub | sw_c_in};
               exp_r = {full[SW],
                        (sw_a[SW-1] == be[SW-1]) && (full[SW-1] != sw_a[SW-1]),
                        full[SW-1:0] == '0,
                        full[SW-1:0]};
               q.push_back(exp_r);
               sent++;
            end
         end
         chk($sformatf("sweep%0d_drained", SW), {sent == NOPS, q.size() == 0}, 2'b11);
         sweeps_done++;
      end
   end

endmodule
